// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer, the hazard unit and
// the decoder: funct codes, sequencer states and the sequence length.
package muldiv_pkg;

    localparam int MULDIV_WIDTH  = 32;
    // Cycles that busy stays high for one mul/div: WIDTH iterations plus FIX.
    localparam int MULDIV_CYCLES = MULDIV_WIDTH + 1;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // True for the four funct codes that start a multi-cycle sequence.
    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) ||
               (fn == FN_DIV)  || (fn == FN_DIVU);
    endfunction

    // True for the signed variants, whose operands are taken by magnitude.
    function automatic logic is_signed_op(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_DIV);
    endfunction

    // True for the divide variants.
    function automatic logic is_div_op(input logic [5:0] fn);
        return (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit and owner of the HI/LO registers.
// Operands are reduced to magnitudes, run through WIDTH iterations of
// shift-add or restoring division, and sign-corrected in the FIX state.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two's complement negation of an operand-width value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed operand; 0x80..0 maps onto itself as unsigned.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: product; div: {rem, quo}
    logic [WIDTH-1:0]   a_q, a_d;         // multiplicand / dividend magnitude
    logic [WIDTH-1:0]   b_q, b_d;         // multiplier / divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH+1:0]   diff_s;
    logic               diff_ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign op_signed_s = is_signed_op(funct);

    // Single adder for the multiply step: upper half plus gated multiplicand.
    assign mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};

    // Restoring-divide step: bring in the next dividend bit, trial-subtract.
    assign rem_sh_s  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign diff_s    = {1'b0, rem_sh_s} - {2'b00, b_q};
    assign diff_ge_s = ~diff_s[WIDTH+1];

    // Sign-corrected results presented during FIX.
    assign prod_s = (neg_a_q ^ neg_b_q) ? neg_dw(acc_q) : acc_q;
    assign quo_s  = div0_q ? {WIDTH{1'b1}} :
                    ((neg_a_q ^ neg_b_q) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
    assign rem_s  = neg_a_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    // State register and all datapath registers; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: IDLE -> RUN on a mul/div, RUN for WIDTH cycles, FIX once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && is_muldiv(funct)) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (count_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, iteration step, result write-back.
    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_muldiv(funct)) begin
                    a_d      = op_signed_s ? mag_w(rs_val) : rs_val;
                    b_d      = op_signed_s ? mag_w(rt_val) : rt_val;
                    neg_a_d  = op_signed_s & rs_val[WIDTH-1];
                    neg_b_d  = op_signed_s & rt_val[WIDTH-1];
                    is_div_d = is_div_op(funct);
                    div0_d   = (rt_val == {WIDTH{1'b0}});
                    acc_d    = {(2*WIDTH){1'b0}};
                    count_d  = {CNT_W{1'b0}};
                end else if (start && (funct == FN_MTHI)) begin
                    hi_d = rs_val;
                end else if (start && (funct == FN_MTLO)) begin
                    lo_d = rs_val;
                end else begin
                    count_d = count_q;
                end
            end
            RUN: begin
                count_d = count_q + CNT_ONE;
                if (is_div_q) begin
                    a_d = {a_q[WIDTH-2:0], 1'b0};
                    if (diff_ge_s) begin
                        acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                count_d = {CNT_W{1'b0}};
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: begin
                count_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs: busy decoded from the state register, the rest straight from flops.
    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction for a single cycle; returns #1 after its edge.
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        funct  = fn;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct  = 6'b000000;
    endtask

    // Issue a mul/div and wait (bounded) until busy drops; reports busy length.
    task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output bit early_done);
        issue(fn, a, b);
        cyc = 0;
        early_done = 1'b0;
        while (busy === 1'b1 && cyc < 200) begin
            if (done === 1'b1) early_done = 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_mult_signed();
        int cyc; bit early;
        do_op(FN_MULT, 32'hFFFF_FFFF, 32'h0000_0002, cyc, early);
        checks++; if (cyc !== MULDIV_CYCLES) begin errors++; $display("FAIL mult_busy_len: got %0d expected %0d", cyc, MULDIV_CYCLES); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL mult_done_while_busy: got %b expected 0", early); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", done); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo: got %h expected fffffffe", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_multu();
        int cyc; bit early;
        do_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, early);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b expected 1", done); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_div_signed();
        int cyc; bit early;
        do_op(FN_DIV, 32'hFFFF_FFF9, 32'h0000_0002, cyc, early);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        do_op(FN_DIV, 32'h0000_0007, 32'hFFFF_FFFE, cyc, early);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_negdivisor_hi: got %h expected 00000001", hi); end
    endtask

    // DIVU 100/7 with stray MTHI and MULT starts injected mid-sequence.
    task automatic test_divu_busy_ignore();
        int cyc;
        logic [31:0] hi_before;
        hi_before = hi;
        issue(FN_DIVU, 32'd100, 32'd7);
        cyc = 0;
        for (int k = 0; k < 200 && busy === 1'b1; k++) begin
            if (k == 4) begin
                start = 1'b1; funct = FN_MTHI; rs_val = 32'hDEAD_BEEF;
            end else if (k == 5) begin
                checks++; if (hi !== hi_before) begin errors++; $display("FAIL mthi_while_busy: got %h expected %h", hi, hi_before); end
                start = 1'b1; funct = FN_MULT; rs_val = 32'd3; rt_val = 32'd3;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++; if (cyc !== MULDIV_CYCLES) begin errors++; $display("FAIL divu_busy_len: got %0d expected %0d", cyc, MULDIV_CYCLES); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL divu_done: got %b expected 1", done); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_no_restart: got %b expected 0", busy); end
    endtask

    task automatic test_div_zero();
        int cyc; bit early;
        do_op(FN_DIVU, 32'd5, 32'd0, cyc, early);
        checks++; if (cyc !== MULDIV_CYCLES) begin errors++; $display("FAIL divu0_busy_len: got %0d expected %0d", cyc, MULDIV_CYCLES); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu0_hi: got %h expected 00000005", hi); end
        do_op(FN_DIV, 32'hFFFF_FFFB, 32'd0, cyc, early);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_hi: got %h expected fffffffb", hi); end
    endtask

    task automatic test_overflow();
        int cyc; bit early;
        do_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, early);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_mt();
        @(negedge clk);
        start = 1'b1; funct = FN_MTHI; rs_val = 32'h1234_5678; rt_val = 32'h0;
        @(posedge clk); #1;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        funct = FN_MTLO; rs_val = 32'hCAFE_BABE;
        @(posedge clk); #1;
        checks++; if (lo !== 32'hCAFE_BABE) begin errors++; $display("FAIL mtlo_lo: got %h expected cafebabe", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_hold: got %h expected 12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_busy_done: got %b%b expected 00", busy, done); end
        funct = FN_MFHI; rs_val = 32'h0BAD_F00D;
        @(posedge clk); #1;
        funct = FN_MFLO;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin errors++; $display("FAIL mf_ignored: got %h/%h expected 12345678/cafebabe", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mf_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int cyc; bit early; bit saw;
        issue(FN_MULT, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo: got %h/%h expected 00000000/00000000", hi, lo); end
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", saw); end
        do_op(FN_MULT, 32'd3, 32'd4, cyc, early);
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL abort_rerun_lo: got %h expected 0000000c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_rerun_hi: got %h expected 00000000", hi); end
    endtask

    // New mul/div presented in the same cycle that done is high.
    task automatic test_back_to_back();
        int cyc; bit early;
        do_op(FN_MULTU, 32'd6, 32'd7, cyc, early);
        checks++; if (done !== 1'b1 || lo !== 32'd42) begin errors++; $display("FAIL b2b_first: got done=%b lo=%h expected done=1 lo=0000002a", done, lo); end
        do_op(FN_DIVU, 32'd42, 32'd5, cyc, early);
        checks++; if (cyc !== MULDIV_CYCLES) begin errors++; $display("FAIL b2b_busy_len: got %0d expected %0d", cyc, MULDIV_CYCLES); end
        checks++; if (lo !== 32'd8) begin errors++; $display("FAIL b2b_lo: got %h expected 00000008", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h expected 00000002", hi); end
        issue(FN_MULTU, 32'd9, 32'd9);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'd2 || lo !== 32'd8) begin errors++; $display("FAIL run_hold_hilo: got %h/%h expected 00000002/00000008", hi, lo); end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; @(posedge clk); #1; end
        checks++; if (lo !== 32'd81 || hi !== 32'd0) begin errors++; $display("FAIL b2b_third: got %h/%h expected 00000000/00000051", hi, lo); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        funct  = 6'b000000;
        rs_val = 32'h0;
        rt_val = 32'h0;
        test_reset();
        test_mult_signed();
        test_multu();
        test_div_signed();
        test_divu_busy_ignore();
        test_div_zero();
        test_overflow();
        test_mt();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
